// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: signed 24-bit A times unsigned 16-bit B.
// Define MULT_RADIX4_EN to retire two multiplier bits per cycle (8 cycles instead of 16).
module shift_add_mult (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [23:0] op_a_i,
    input  logic [15:0] op_b_i,
    output logic        ready_o,
    output logic [39:0] prod_o
);

`ifdef MULT_RADIX4_EN
    localparam int unsigned STEP = 2;
    localparam logic [3:0]  LAST = 4'd7;
`else
    localparam int unsigned STEP = 1;
    localparam logic [3:0]  LAST = 4'd15;
`endif

    typedef enum logic {
        S_IDLE,
        S_CALC
    } state_t;

    state_t      r_state;
    logic [39:0] r_a;
    logic [39:0] r_acc;
    logic [39:0] r_prod;
    logic [15:0] r_b;
    logic [3:0]  r_cnt;
    logic        r_ready;

    logic [39:0] w_a_ext;
    logic [39:0] w_addend;
    logic [39:0] w_acc_nxt;

    assign w_a_ext = {{16{op_a_i[23]}}, op_a_i};

`ifdef MULT_RADIX4_EN
    // 3A is kept in its own shifted register so each step is a single add
    logic [39:0] r_a3;

    always_comb begin
        w_addend = '0;
        unique case (r_b[1:0])
            2'd0:    w_addend = '0;
            2'd1:    w_addend = r_a;
            2'd2:    w_addend = {r_a[38:0], 1'b0};
            default: w_addend = r_a3;
        endcase
    end
`else
    assign w_addend = r_b[0] ? r_a : '0;
`endif

    assign w_acc_nxt = r_acc + w_addend;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_ready <= 1'b1;
`ifdef MULT_RADIX4_EN
            r_a3    <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_a     <= w_a_ext;
                        r_b     <= op_b_i;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_CALC;
`ifdef MULT_RADIX4_EN
                        r_a3    <= w_a_ext + {w_a_ext[38:0], 1'b0};
`endif
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_a   <= r_a << STEP;
                    r_b   <= r_b >> STEP;
                    r_cnt <= r_cnt + 4'd1;
`ifdef MULT_RADIX4_EN
                    r_a3  <= r_a3 << STEP;
`endif
                    if (r_cnt == LAST) begin
                        r_prod  <= w_acc_nxt;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign prod_o  = r_prod;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult against an arithmetic reference model.
// Build with +define+MULT_RADIX4_EN to check the radix-4 latency.
module tb_shift_add_mult;

`ifdef MULT_RADIX4_EN
    localparam int N = 8;
`else
    localparam int N = 16;
`endif
    localparam int NRAND = 2000;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic [23:0] op_a_i;
    logic [15:0] op_b_i;
    logic        ready_o;
    logic [39:0] prod_o;

    int n_cmp;
    int n_err;

    shift_add_mult dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .op_a_i  (op_a_i),
        .op_b_i  (op_b_i),
        .ready_o (ready_o),
        .prod_o  (prod_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [39:0] ref_mul(input logic [23:0] a,
                                            input logic [15:0] b);
        longint sa;
        longint pr;
        sa = longint'($signed(a));
        pr = sa * longint'({48'd0, b});
        return pr[39:0];
    endfunction

    task automatic do_op(input logic [23:0] a, input logic [15:0] b,
                         output int lat, output logic [39:0] p,
                         output bit held);
        logic [39:0] prev;
        int w;
        w = 0;
        while (ready_o !== 1'b1 && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        prev    = prod_o;
        start_i = 1'b1;
        op_a_i  = a;
        op_b_i  = b;
        @(negedge clk_i);
        start_i = 1'b0;
        op_a_i  = 24'($urandom);
        op_b_i  = 16'($urandom);
        lat  = 0;
        held = 1'b1;
        while (ready_o === 1'b0 && lat < 100) begin
            if (prod_o !== prev) held = 1'b0;
            lat++;
            @(negedge clk_i);
        end
        p = prod_o;
    endtask

    task automatic test_reset;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        op_a_i  = '0;
        op_b_i  = '0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready got=%b exp=1", ready_o);
        end
        n_cmp++;
        if (prod_o !== 40'h0) begin
            n_err++;
            $display("FAIL reset_prod got=%h exp=0", prod_o);
        end
    endtask

    task automatic test_directed;
        logic [23:0] ta [6];
        logic [15:0] tb [6];
        logic [39:0] te [6];
        int lat;
        logic [39:0] p;
        bit held;
        ta[0] = 24'hFFFE00; tb[0] = 16'h00FF; te[0] = 40'hFFFFFE0200;
        ta[1] = 24'h7FFFFF; tb[1] = 16'hFFFF; te[1] = 40'h7FFF7F0001;
        ta[2] = 24'h800000; tb[2] = 16'hFFFF; te[2] = 40'h8000800000;
        ta[3] = 24'h123456; tb[3] = 16'h0000; te[3] = 40'h0;
        ta[4] = 24'h000000; tb[4] = 16'hBEEF; te[4] = 40'h0;
        ta[5] = 24'hFFFFFF; tb[5] = 16'h0001; te[5] = 40'hFFFFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], lat, p, held);
            n_cmp++;
            if (p !== te[i]) begin
                n_err++;
                $display("FAIL directed_prod[%0d] got=%h exp=%h", i, p, te[i]);
            end
            n_cmp++;
            if (lat != N) begin
                n_err++;
                $display("FAIL directed_lat[%0d] got=%0d exp=%0d", i, lat, N);
            end
            n_cmp++;
            if (!held) begin
                n_err++;
                $display("FAIL directed_hold[%0d] got=changed exp=held", i);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int w;
        do_op(24'd1, 16'd1, w, op_a_i, start_i);
        start_i = 1'b0;
        start_i = 1'b1;
        op_a_i  = 24'd3;
        op_b_i  = 16'd5;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        start_i = 1'b1;
        op_a_i  = 24'd7;
        op_b_i  = 16'd7;
        repeat (3) @(negedge clk_i);
        start_i = 1'b0;
        w = 0;
        while (ready_o !== 1'b1 && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        n_cmp++;
        if (prod_o !== 40'd15) begin
            n_err++;
            $display("FAIL busy_prod got=%0d exp=15", prod_o);
        end
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (ready_o !== 1'b1 || prod_o !== 40'd15) begin
            n_err++;
            $display("FAIL busy_ghost got=%b/%0d exp=1/15", ready_o, prod_o);
        end
    endtask

    task automatic test_back_to_back;
        int w;
        int lat;
        start_i = 1'b1;
        op_a_i  = 24'd3;
        op_b_i  = 16'd5;
        @(negedge clk_i);
        start_i = 1'b0;
        w = 0;
        while (ready_o !== 1'b1 && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        n_cmp++;
        if (prod_o !== 40'd15) begin
            n_err++;
            $display("FAIL b2b_first got=%0d exp=15", prod_o);
        end
        start_i = 1'b1;
        op_a_i  = 24'd7;
        op_b_i  = 16'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        lat = 0;
        while (ready_o === 1'b0 && lat < 100) begin
            lat++;
            @(negedge clk_i);
        end
        n_cmp++;
        if (lat != N) begin
            n_err++;
            $display("FAIL b2b_lat got=%0d exp=%0d", lat, N);
        end
        n_cmp++;
        if (prod_o !== 40'd49) begin
            n_err++;
            $display("FAIL b2b_prod got=%0d exp=49", prod_o);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [39:0] p;
        bit held;
        start_i = 1'b1;
        op_a_i  = 24'd100;
        op_b_i  = 16'd100;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (ready_o !== 1'b1 || prod_o !== 40'h0) begin
            n_err++;
            $display("FAIL midreset got=%b/%h exp=1/0", ready_o, prod_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (prod_o !== 40'h0) begin
            n_err++;
            $display("FAIL midreset_partial got=%h exp=0", prod_o);
        end
        do_op(24'd2, 16'd3, lat, p, held);
        n_cmp++;
        if (p !== 40'd6 || lat != N) begin
            n_err++;
            $display("FAIL postreset got=%0d/%0d exp=6/%0d", p, lat, N);
        end
    endtask

    task automatic test_random;
        logic [23:0] a;
        logic [15:0] b;
        logic [39:0] exp_p;
        logic [39:0] p;
        int lat;
        bit held;
        for (int i = 0; i < NRAND; i++) begin
            a = 24'($urandom);
            b = 16'($urandom);
            if (i % 50 == 0) a = 24'h800000;
            if (i % 50 == 1) b = 16'hFFFF;
            exp_p = ref_mul(a, b);
            do_op(a, b, lat, p, held);
            n_cmp++;
            if (p !== exp_p || lat != N || !held) begin
                n_err++;
                $display("FAIL rand[%0d] a=%h b=%h got=%h/%0d/%b exp=%h/%0d/1",
                         i, a, b, p, lat, held, exp_p, N);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        op_a_i  = '0;
        op_b_i  = '0;
        test_reset;
        test_directed;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
